// File: rtl/load_align_unit.sv
// Load path: issues a word-aligned read with byte enables, then extracts and
// sign/zero-extends the addressed byte, half or word for writeback.
module load_align_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        ld_busy,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ld_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        off_q, size_q;
  logic              sgn_q;
  logic [31:0]       addr_q;
  logic [7:0]        cnt_q, cnt_nxt;
  logic [31:0]       data_q, data_nxt;
  logic              err_q, err_nxt;
  logic              misalign;
  logic [3:0][7:0]   rbytes;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [31:0]       ext;

  assign rbytes = mem_rdata;
  assign bsel   = rbytes[off_q];
  assign hsel   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{sgn_q & bsel[7]}}, bsel};
      2'b01:   ext = {{16{sgn_q & hsel[15]}}, hsel};
      default: ext = mem_rdata;
    endcase
  end

  // Reserved size is folded into the misaligned path so it never touches memory.
  assign misalign = (ld_size == 2'b11) ||
                    (ld_size == 2'b01 && ld_addr[0]) ||
                    (ld_size == 2'b10 && ld_addr[1:0] != 2'b00);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    err_nxt   = err_q;
    case (state)
      IDLE: if (ld_req) begin
        if (misalign) begin
          state_nxt = RESP;
          data_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: if (mem_gnt) begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = RESP;
          data_nxt  = ext;
          err_nxt   = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          data_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      off_q  <= '0;
      size_q <= '0;
      sgn_q  <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
      if (state == IDLE && ld_req) begin
        off_q  <= ld_addr[1:0];
        size_q <= ld_size;
        sgn_q  <= ld_signed;
        addr_q <= {ld_addr[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    mem_be = 4'b0000;
    if (state == REQ) begin
      case (size_q)
        2'b00:   mem_be = 4'b0001 << off_q;
        2'b01:   mem_be = 4'b0011 << off_q;
        default: mem_be = 4'b1111;
      endcase
    end
  end

  assign ld_busy  = (state != IDLE);
  assign ld_valid = (state == RESP);
  assign mem_req  = (state == REQ);
  assign mem_addr = addr_q;
  assign ld_data  = data_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboarded bench for load_align_unit: directed cases, random loads,
// timeout, late response and mid-transaction reset.
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [1:0]  ld_size = '0;
  logic        ld_signed = 1'b0;
  logic        ld_busy, ld_valid, ld_err, mem_req;
  logic [31:0] ld_data, mem_addr;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct { logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  load_align_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_signed(ld_signed), .ld_busy(ld_busy), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_err(ld_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: shift the addressed bytes down, mask to width, then extend arithmetically.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] rd);
    exp_t   e;
    int     nb;
    longint v;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    e.data = '0;
    e.err  = 1'b0;
    if (sz == 3 || (a % nb) != 0) begin
      e.err = 1'b1;
      return e;
    end
    v = (longint'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 1);
    if (sg && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    e.data = v[31:0];
    return e;
  endfunction

  function automatic logic [3:0] be_model(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  // Monitor: every ld_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ld_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ld_data", ld_data, e.data);
        chk("ld_err", {31'd0, ld_err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] rd, input int gdly, input int rdly);
    exp_t e;
    e = model(a, sz, sg, rd);
    sb.push_back(e);
    ld_req = 1'b1; ld_addr = a; ld_size = sz; ld_signed = sg;
    tick();
    ld_req = 1'b0; ld_addr = $urandom; ld_size = 2'($urandom); ld_signed = 1'($urandom);
    if (e.err) begin
      chk("mis_no_mem_req", {31'd0, mem_req}, 32'd0);
      chk("mis_latency", {31'd0, ld_valid}, 32'd1);
      tick();
      return;
    end
    for (int i = 0; i <= gdly; i++) begin
      chk("mem_req_held", {31'd0, mem_req}, 32'd1);
      chk("busy_req", {31'd0, ld_busy}, 32'd1);
      chk("mem_be", {28'd0, mem_be}, {28'd0, be_model(a, sz)});
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      mem_gnt = (i == gdly);
      tick();
    end
    mem_gnt = 1'b0;
    chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < rdly; i++) begin
      chk("busy_wait", {31'd0, ld_busy}, 32'd1);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    chk("resp_latency", {31'd0, ld_valid}, 32'd1);
    tick();
    chk("idle_after", {31'd0, ld_busy | ld_valid}, 32'd0);
  endtask

  initial begin
    int k;
    #12;
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_outs", {31'd0, ld_valid | ld_err | mem_req | (|mem_be) | (|ld_data) | (|mem_addr)}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_load(32'h0000_1002, 2'b00, 1'b1, 32'h1280_3456, 0, 0);
    do_load(32'h0000_1002, 2'b00, 1'b0, 32'h1280_3456, 0, 0);
    do_load(32'h0000_2002, 2'b01, 1'b1, 32'hBEEF_1234, 0, 0);
    do_load(32'h0000_3001, 2'b10, 1'b0, 32'hFFFF_FFFF, 0, 0);
    do_load(32'h0000_4000, 2'b11, 1'b1, 32'h1234_5678, 0, 0);
    do_load(32'h0000_5003, 2'b01, 1'b1, 32'h1234_5678, 0, 0);
    do_load(32'h0000_6004, 2'b10, 1'b1, 32'h8765_4321, 3, 0);
    do_load(32'h0000_7003, 2'b00, 1'b1, 32'h7F00_0000, 1, 2);

    for (int n = 0; n < 300; n++)
      do_load($urandom, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
              $urandom_range(0, 2));

    // Timeout: grant, then no rvalid; expect error after four WAIT cycles.
    sb.push_back('{data: 32'd0, err: 1'b1});
    ld_req = 1'b1; ld_addr = 32'h0000_8000; ld_size = 2'b10;
    tick();
    ld_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    k = 0;
    while (!ld_valid && k < 20) begin
      tick();
      k++;
    end
    chk("timeout_cycles", k, 32'd4);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_ignored", {31'd0, ld_busy | ld_valid}, 32'd0);

    // Reset in WAIT after a load that leaves nonzero data.
    do_load(32'h0000_9000, 2'b10, 1'b0, 32'hCAFE_F00D, 0, 0);
    ld_req = 1'b1; ld_addr = 32'h0000_A004; ld_size = 2'b10;
    tick();
    ld_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, ld_busy}, 32'd0);
    chk("midrst_outs", {31'd0, ld_valid | ld_err | mem_req | (|mem_be) | (|ld_data) | (|mem_addr)}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("post_rst_idle", {31'd0, ld_busy | ld_valid}, 32'd0);
    do_load(32'h0000_B001, 2'b00, 1'b1, 32'h0000_8100, 2, 1);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
